// File: rtl/retire_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : retire_stage_pkg
// Description : Shared types for the retire stage: operations, FSM states,
//               trap cause codes and a load-classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package retire_stage_pkg;

    typedef enum logic [4:0] {
        NOP, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, LUI,
        LB, LBU, LH, LHU, LW, SB, SH, SW,
        BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR
    } iType_e;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } retireState_e;

    typedef enum logic [3:0] {
        INSTRUCTION_ADDRESS_MISALIGNED = 4'd0,
        ILLEGAL_INSTRUCTION            = 4'd2,
        LOAD_ACCESS_FAULT              = 4'd5
    } exceptionCode_e;

    function automatic logic is_load(iType_e op);
        return op inside {LB, LBU, LH, LHU, LW};
    endfunction

endpackage
`default_nettype wire

// File: rtl/retire_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : retire_stage_if
// Description : Registered execute-stage outputs consumed by the retire stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface retire_stage_if;
    import retire_stage_pkg::*;

    logic [31:0]      instruction_i;
    logic [31:0]      pc_i;
    iType_e           instruction_operation_i;
    logic [1:0][31:0] result_i;
    logic [2:0]       tag_i;
    logic             jump_i;
    logic             write_enable_i;
    logic             exc_ilegal_inst_i;
    logic             exc_misaligned_fetch_i;

    modport master (
        output instruction_i, pc_i, instruction_operation_i, result_i, tag_i,
               jump_i, write_enable_i, exc_ilegal_inst_i, exc_misaligned_fetch_i
    );

    modport slave (
        input  instruction_i, pc_i, instruction_operation_i, result_i, tag_i,
               jump_i, write_enable_i, exc_ilegal_inst_i, exc_misaligned_fetch_i
    );

endinterface
`default_nettype wire

// File: rtl/retire_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Extracts the addressed byte/halfword of a load and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import retire_stage_pkg::*;
(
    input  iType_e      i_op,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr)
            2'd0:    w_byte = i_data[7:0];
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            default: w_byte = i_data[31:24];
        endcase
        w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];

        case (i_op)
            LB:      o_data = {{24{w_byte[7]}}, w_byte};
            LBU:     o_data = {24'h000000, w_byte};
            LH:      o_data = {{16{w_half[15]}}, w_half};
            LHU:     o_data = {16'h0000, w_half};
            default: o_data = i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/retire_stage.sv
`default_nettype none
// ============================================================================
// Module      : retire_stage
// Description : Commit stage: writeback, load alignment, redirects, traps and
//               wrong-path squashing via the pipeline tag.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 255
)
(
    input  logic                 clk,
    input  logic                 reset,
    retire_stage_if.slave        ex,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_ready_i,
    input  logic [31:0]          mtvec_i,
    output logic                 regbank_write_enable_o,
    output logic [4:0]           regbank_address_o,
    output logic [31:0]          regbank_data_o,
    output logic                 jump_o,
    output logic [31:0]          jump_target_o,
    output logic [2:0]           current_tag_o,
    output logic                 stall_o,
    output logic                 exception_o,
    output logic [3:0]           exception_cause_o,
    output logic [31:0]          exception_pc_o,
    output logic                 instruction_retired_o,
    output logic                 killed_o
);

    localparam int                c_CNT_W   = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(LOAD_TIMEOUT);

    retireState_e       r_state, w_state_next;
    logic [2:0]         r_tag, w_tag_next;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_next;

    logic               w_valid, w_load, w_timeout, w_exc, w_stall, w_done, w_redirect, w_we;
    exceptionCode_e     w_cause;
    logic [4:0]         w_rd;
    logic [31:0]        w_load_data;
    logic               w_unused_bits;

    assign w_rd          = ex.instruction_i[11:7];
    assign w_unused_bits = ^{ex.instruction_i[31:12], ex.instruction_i[6:0]};

    load_align u_load_align (
        .i_op   (ex.instruction_operation_i),
        .i_addr (ex.result_i[0][1:0]),
        .i_data (mem_data_i),
        .o_data (w_load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_tag   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_tag   <= w_tag_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tag_next   = r_tag;
        w_cnt_next   = r_cnt;
        w_exc        = 1'b0;
        w_cause      = INSTRUCTION_ADDRESS_MISALIGNED;

        w_valid   = (ex.tag_i == r_tag);
        w_load    = w_valid && is_load(ex.instruction_operation_i);
        w_timeout = (r_state == LOAD_WAIT) && (r_cnt == c_TIMEOUT) && !mem_ready_i;

        if (w_valid) begin
            if (ex.exc_misaligned_fetch_i) begin
                w_exc   = 1'b1;
                w_cause = INSTRUCTION_ADDRESS_MISALIGNED;
            end else if (ex.exc_ilegal_inst_i) begin
                w_exc   = 1'b1;
                w_cause = ILLEGAL_INSTRUCTION;
            end else if (w_load && w_timeout) begin
                w_exc   = 1'b1;
                w_cause = LOAD_ACCESS_FAULT;
            end
        end

        // A trap always wins over a pending load, so stall and redirect stay exclusive
        w_stall    = w_load && !w_exc && !mem_ready_i;
        w_done     = w_valid && !w_exc && !w_stall;
        w_redirect = w_exc || (w_valid && ex.jump_i && !w_stall);
        w_we       = w_done && ex.write_enable_i && (w_rd != 5'd0);

        regbank_write_enable_o = 1'b0;
        regbank_address_o      = 5'd0;
        regbank_data_o         = 32'h0;
        jump_o                 = 1'b0;
        jump_target_o          = 32'h0;
        current_tag_o          = r_tag;
        stall_o                = 1'b0;
        exception_o            = 1'b0;
        exception_cause_o      = 4'd0;
        exception_pc_o         = 32'h0;
        instruction_retired_o  = 1'b0;
        killed_o               = 1'b0;

        if (!reset) begin
            regbank_write_enable_o = w_we;
            if (w_we) begin
                regbank_address_o = w_rd;
                regbank_data_o    = is_load(ex.instruction_operation_i) ? w_load_data : ex.result_i[0];
            end
            jump_o = w_redirect;
            if (w_redirect) begin
                jump_target_o = w_exc ? mtvec_i : ex.result_i[1];
            end
            stall_o     = w_stall;
            exception_o = w_exc;
            if (w_exc) begin
                exception_cause_o = w_cause;
                exception_pc_o    = ex.pc_i;
            end
            instruction_retired_o = w_done;
            killed_o              = !w_valid;
        end

        if (w_redirect) begin
            w_tag_next = r_tag + 3'd1;
        end

        case (r_state)
            RUN: begin
                if (w_stall) begin
                    w_state_next = LOAD_WAIT;
                    w_cnt_next   = c_CNT_W'(1);
                end
            end
            LOAD_WAIT: begin
                if (w_stall) begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end else begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
